// File: rtl/wb_arb_pkg.sv
// ---------------------------------------------------------------------------
// wb_arb_pkg
// Shared definitions for the writeback-port arbiter:
//   - writeback mux select encodings (ALU / MEM / LINK / mult-div)
//   - pending-result entry layout {valid, rd, data}
//   - REG_ZERO, the hard-wired zero register address
//   - helper to size the occupancy counter of a DEPTH-entry FIFO
// ---------------------------------------------------------------------------
package wb_arb_pkg;

    // Writeback mux select encodings. SEL_MD is never legal from the pipe.
    localparam logic [1:0] SEL_ALU  = 2'b00;
    localparam logic [1:0] SEL_MEM  = 2'b01;
    localparam logic [1:0] SEL_LINK = 2'b10;
    localparam logic [1:0] SEL_MD   = 2'b11;

    // Default datapath geometry of the MIPS core.
    localparam int PEND_NB_ADDR = 5;
    localparam int PEND_NB_DATA = 32;

    localparam logic [PEND_NB_ADDR-1:0] REG_ZERO = '0;

    // Pending late result at the default geometry. The FIFO re-declares the
    // same field order at its own parameter widths.
    typedef struct packed {
        logic                    valid;
        logic [PEND_NB_ADDR-1:0] rd;
        logic [PEND_NB_DATA-1:0] data;
    } pend_entry_t;

    // Bits needed to hold 0..depth.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// wb_port_arbiter_if
// Bundles the pipeline writeback request, the mult/div result handshake and
// the register-file write port controls seen by wb_port_arbiter.
//   slave  : arbiter side (consumes requests, drives RF port / stall)
//   master : environment side (pipeline + mult/div unit + RF)
// Signals:
//   pipe_valid_i, pipe_we_i, pipe_rd_i, pipe_sel_i  MEM/WB write request
//   md_valid_i, md_rd_i, md_data_i / md_ready_o      late-result handshake
//   wb_sel_o, md_data_o, rf_we_o, rf_addr_o          RF write port
//   stall_o                                          freeze MEM/WB + upstream
//   pend_count_o                                     occupied FIFO entries
// ---------------------------------------------------------------------------
interface wb_port_arbiter_if #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 5,
    parameter int NB_SEL  = 2,
    parameter int DEPTH   = 2
);
    logic                         pipe_valid_i;
    logic                         pipe_we_i;
    logic [NB_ADDR-1:0]           pipe_rd_i;
    logic [NB_SEL-1:0]            pipe_sel_i;
    logic                         md_valid_i;
    logic [NB_ADDR-1:0]           md_rd_i;
    logic [NB_DATA-1:0]           md_data_i;
    logic                         md_ready_o;
    logic [NB_SEL-1:0]            wb_sel_o;
    logic [NB_DATA-1:0]           md_data_o;
    logic                         rf_we_o;
    logic [NB_ADDR-1:0]           rf_addr_o;
    logic                         stall_o;
    logic [$clog2(DEPTH+1)-1:0]   pend_count_o;

    modport slave (
        input  pipe_valid_i, pipe_we_i, pipe_rd_i, pipe_sel_i,
        input  md_valid_i, md_rd_i, md_data_i,
        output md_ready_o, wb_sel_o, md_data_o, rf_we_o, rf_addr_o,
        output stall_o, pend_count_o
    );

    modport master (
        output pipe_valid_i, pipe_we_i, pipe_rd_i, pipe_sel_i,
        output md_valid_i, md_rd_i, md_data_i,
        input  md_ready_o, wb_sel_o, md_data_o, rf_we_o, rf_addr_o,
        input  stall_o, pend_count_o
    );

endinterface

// File: rtl/wb_pend_fifo.sv
// ---------------------------------------------------------------------------
// wb_pend_fifo
// DEPTH-entry circular FIFO of pending mult/div results. Every entry carries
// a valid bit that can be cleared in place by the squash port, so a result
// overwritten by a younger pipeline write drains as a no-op instead of
// clobbering the newer value.
// Ports:
//   clock_i, reset_i (async, active-low)
//   push_i, push_rd_i, push_data_i     enqueue (caller guarantees not full)
//   pop_i                              dequeue head (ignored when empty)
//   head_valid_o, head_rd_o, head_data_o  current head entry
//   count_o                            occupied entries
//   squash_en_i, squash_rd_i           clear valid of entries with this rd,
//                                      including an entry pushed this cycle
// ---------------------------------------------------------------------------
module wb_pend_fifo
    import wb_arb_pkg::*;
#(
    parameter int NB_DATA = PEND_NB_DATA,
    parameter int NB_ADDR = PEND_NB_ADDR,
    parameter int DEPTH   = 2
) (
    input  logic                       clock_i,
    input  logic                       reset_i,
    input  logic                       push_i,
    input  logic [NB_ADDR-1:0]         push_rd_i,
    input  logic [NB_DATA-1:0]         push_data_i,
    input  logic                       pop_i,
    output logic                       head_valid_o,
    output logic [NB_ADDR-1:0]         head_rd_o,
    output logic [NB_DATA-1:0]         head_data_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    input  logic                       squash_en_i,
    input  logic [NB_ADDR-1:0]         squash_rd_i
);

    localparam int CNT_W = cnt_width(DEPTH);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic               valid;
        logic [NB_ADDR-1:0] rd;
        logic [NB_DATA-1:0] data;
    } entry_t;

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               push_ok;
    logic               pop_ok;
    entry_t             push_entry;
    logic [DEPTH-1:0]   squash_hit;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign push_ok = push_i & (count_q < CNT_W'(DEPTH));
    assign pop_ok  = pop_i & (count_q != '0);

    // A result pushed in the same cycle the pipe writes its rd is already stale.
    assign push_entry.valid = ~(squash_en_i && (push_rd_i == squash_rd_i));
    assign push_entry.rd    = push_rd_i;
    assign push_entry.data  = push_data_i;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_squash
            assign squash_hit[gi] = squash_en_i && (mem_q[gi].rd == squash_rd_i);
        end
    endgenerate

    always_comb begin
        wr_ptr_d = push_ok ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                // A push only ever targets a free slot, so it never collides
                // with a squash of a live entry.
                if (push_ok && (wr_ptr_q == PTR_W'(i))) begin
                    mem_q[i] <= push_entry;
                end else if (squash_hit[i]) begin
                    mem_q[i].valid <= 1'b0;
                end
            end
        end
    end

    assign head_valid_o = mem_q[rd_ptr_q].valid;
    assign head_rd_o    = mem_q[rd_ptr_q].rd;
    assign head_data_o  = mem_q[rd_ptr_q].data;
    assign count_o      = count_q;

endmodule

// File: rtl/wb_port_arbiter.sv
// ---------------------------------------------------------------------------
// wb_port_arbiter
// Owns the single register-file write port at the end of the MIPS pipeline.
// Arbitrates between the in-order MEM/WB writeback and late mult/div results
// that wait in a small pending FIFO. If the pipe keeps winning while results
// are pending, a starvation counter forces a one-cycle stall to drain one.
// Ports:
//   clock_i        single clock
//   reset_i        asynchronous, active-low reset
//   bus (slave)    pipe request, md handshake, RF port controls, stall_o,
//                  pend_count_o (see wb_port_arbiter_if)
// Build option:
//   WB_ARB_BYPASS_EN  when defined, a result arriving with the FIFO empty, no
//                     pipe write and no stall is written in the same cycle
//                     instead of being queued.
// ---------------------------------------------------------------------------
module wb_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NB_DATA      = 32,
    parameter int NB_ADDR      = 5,
    parameter int NB_SEL       = 2,
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clock_i,
    input  logic              reset_i,
    wb_port_arbiter_if.slave  bus
);

    localparam int CNT_W = cnt_width(DEPTH);
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0]   count;
    logic               head_valid;
    logic [NB_ADDR-1:0] head_rd;
    logic [NB_DATA-1:0] head_data;

    logic               pwr;
    logic               stall;
    logic               fifo_nonempty;
    logic               pop;
    logic               pipe_grant;
    logic               md_ready;
    logic               md_accept;
    logic               md_rd_nz;
    logic               bypass_hit;
    logic               push;

    logic [STV_W-1:0]   starve_q, starve_d;

    // ---------------------------------------------------------------- request
    assign pwr           = bus.pipe_valid_i & bus.pipe_we_i &
                           (bus.pipe_rd_i != NB_ADDR'(REG_ZERO));
    assign stall         = (starve_q == STV_W'(STARVE_LIMIT));
    assign fifo_nonempty = (count != '0);

    // Forced drain wins outright; otherwise the FIFO only gets idle cycles.
    assign pop        = stall | (~pwr & fifo_nonempty);
    assign pipe_grant = ~stall & pwr;

    // Ready comes from the registered count, so a pop frees a slot only
    // for the following cycle.
    assign md_ready  = (count < CNT_W'(DEPTH));
    assign md_accept = bus.md_valid_i & md_ready;
    assign md_rd_nz  = (bus.md_rd_i != NB_ADDR'(REG_ZERO));

`ifdef WB_ARB_BYPASS_EN
    assign bypass_hit = md_accept & md_rd_nz & ~fifo_nonempty & ~pwr & ~stall;
`else
    assign bypass_hit = 1'b0;
`endif

    // Results for r0 are acknowledged but dropped.
    assign push = md_accept & md_rd_nz & ~bypass_hit;

    wb_pend_fifo #(
        .NB_DATA (NB_DATA),
        .NB_ADDR (NB_ADDR),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clock_i      (clock_i),
        .reset_i      (reset_i),
        .push_i       (push),
        .push_rd_i    (bus.md_rd_i),
        .push_data_i  (bus.md_data_i),
        .pop_i        (pop),
        .head_valid_o (head_valid),
        .head_rd_o    (head_rd),
        .head_data_o  (head_data),
        .count_o      (count),
        .squash_en_i  (pipe_grant),
        .squash_rd_i  (bus.pipe_rd_i)
    );

    // ------------------------------------------------------ starvation count
    always_comb begin
        starve_d = starve_q;
        if (stall || pop || !fifo_nonempty) begin
            starve_d = '0;
        end else if (pipe_grant) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

    // ------------------------------------------------------------ write port
    // Outputs are held idle while reset is asserted so a request still sitting
    // in MEM/WB cannot write during reset.
    always_comb begin
        bus.rf_we_o   = 1'b0;
        bus.wb_sel_o  = NB_SEL'(SEL_ALU);
        bus.rf_addr_o = '0;
        bus.md_data_o = '0;
        if (reset_i) begin
            if (pop) begin
                // A squashed head burns the slot as a no-op.
                if (head_valid) begin
                    bus.rf_we_o   = 1'b1;
                    bus.wb_sel_o  = NB_SEL'(SEL_MD);
                    bus.rf_addr_o = head_rd;
                    bus.md_data_o = head_data;
                end
            end else if (pwr) begin
                bus.rf_we_o   = 1'b1;
                bus.wb_sel_o  = bus.pipe_sel_i;
                bus.rf_addr_o = bus.pipe_rd_i;
            end else if (bypass_hit) begin
                bus.rf_we_o   = 1'b1;
                bus.wb_sel_o  = NB_SEL'(SEL_MD);
                bus.rf_addr_o = bus.md_rd_i;
                bus.md_data_o = bus.md_data_i;
            end
        end
    end

    assign bus.md_ready_o   = md_ready;
    assign bus.stall_o      = stall;
    assign bus.pend_count_o = count;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_port_arbiter
// Cycle-by-cycle vector table for the writeback arbiter (reset, latency,
// starvation stall, squash, backpressure, r0 drop), an asynchronous reset
// sequence, and a scoreboarded stream of mult/div results.
// ---------------------------------------------------------------------------
module tb_wb_port_arbiter;
    import wb_arb_pkg::*;

    localparam int NB_DATA      = 32;
    localparam int NB_ADDR      = 5;
    localparam int NB_SEL       = 2;
    localparam int DEPTH        = 2;
    localparam int STARVE_LIMIT = 4;
`ifdef WB_ARB_BYPASS_EN
    localparam int LAT_MIN = 0;
`else
    localparam int LAT_MIN = 1;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wb_port_arbiter_if #(
        .NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR), .NB_SEL(NB_SEL), .DEPTH(DEPTH)
    ) bus_if ();

    wb_port_arbiter #(
        .NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR), .NB_SEL(NB_SEL),
        .DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clock_i (clk),
        .reset_i (rst_n),
        .bus     (bus_if)
    );

    typedef struct {
        logic        pv, pw;
        logic [4:0]  prd;
        logic [1:0]  psel;
        logic        mv;
        logic [4:0]  mrd;
        logic [31:0] mdat;
        logic        we;
        logic [1:0]  sel;
        logic [4:0]  addr;
        logic [31:0] dat;
        logic        stall;
        logic [1:0]  cnt;
        logic        rdy;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        int          cyc;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic void add_vec(
        input logic pv, input logic pw, input logic [4:0] prd, input logic [1:0] psel,
        input logic mv, input logic [4:0] mrd, input logic [31:0] mdat,
        input logic we, input logic [1:0] sel, input logic [4:0] addr, input logic [31:0] dat,
        input logic stall, input logic [1:0] cnt, input logic rdy);
        vec_t v;
        v.pv = pv; v.pw = pw; v.prd = prd; v.psel = psel;
        v.mv = mv; v.mrd = mrd; v.mdat = mdat;
        v.we = we; v.sel = sel; v.addr = addr; v.dat = dat;
        v.stall = stall; v.cnt = cnt; v.rdy = rdy;
        vecs.push_back(v);
    endfunction

    task automatic drive(input logic pv, input logic pw, input logic [4:0] prd,
                         input logic [1:0] psel, input logic mv, input logic [4:0] mrd,
                         input logic [31:0] mdat);
        bus_if.pipe_valid_i = pv;
        bus_if.pipe_we_i    = pw;
        bus_if.pipe_rd_i    = prd;
        bus_if.pipe_sel_i   = psel;
        bus_if.md_valid_i   = mv;
        bus_if.md_rd_i      = mrd;
        bus_if.md_data_i    = mdat;
    endtask

    // md_data_o is only defined when the mux selects it or nothing is written.
    task automatic check_outs(input string name, input logic we, input logic [1:0] sel,
                              input logic [4:0] addr, input logic [31:0] dat,
                              input logic stall, input logic [1:0] cnt, input logic rdy);
        logic chk_dat;
        logic ok;
        chk_dat = (sel == SEL_MD) || !we;
        ok = (bus_if.rf_we_o === we) && (bus_if.wb_sel_o === sel) &&
             (bus_if.rf_addr_o === addr) && (!chk_dat || (bus_if.md_data_o === dat)) &&
             (bus_if.stall_o === stall) && (bus_if.pend_count_o === cnt) &&
             (bus_if.md_ready_o === rdy);
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got we=%b sel=%b addr=%0d data=%h stall=%b cnt=%0d rdy=%b ; want we=%b sel=%b addr=%0d data=%h stall=%b cnt=%0d rdy=%b",
                     name, bus_if.rf_we_o, bus_if.wb_sel_o, bus_if.rf_addr_o, bus_if.md_data_o,
                     bus_if.stall_o, bus_if.pend_count_o, bus_if.md_ready_o,
                     we, sel, addr, dat, stall, cnt, rdy);
        end else begin
            $display("%s ok: we=%b sel=%b addr=%0d data=%h stall=%b cnt=%0d rdy=%b",
                     name, we, sel, addr, dat, stall, cnt, rdy);
        end
    endtask

    initial begin
        logic [4:0]  o_rd;
        logic [31:0] o_dat;
        logic        offering;
        int          offers_left;
        int          k;
        logic        pbusy;
        sb_t         e;

        drive(0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 check_outs("reset_hold", 0, SEL_ALU, 0, 0, 0, 0, 1);
        @(negedge clk) rst_n = 1'b1;

        // ---------------------------------------------------- vector table
        add_vec(0,0,0,0,        0,0,0,              0,SEL_ALU,0,0,          0,0,1); // idle
        add_vec(1,1,3,SEL_MEM,  0,0,0,              1,SEL_MEM,3,0,          0,0,1); // pipe write
        add_vec(1,0,4,SEL_ALU,  0,0,0,              0,SEL_ALU,0,0,          0,0,1); // valid, no we
        add_vec(1,1,0,SEL_ALU,  0,0,0,              0,SEL_ALU,0,0,          0,0,1); // rd=0 write
`ifdef WB_ARB_BYPASS_EN
        add_vec(0,0,0,0,        1,5,32'hDEADBEEF,   1,SEL_MD,5,32'hDEADBEEF,0,0,1); // bypass
        add_vec(0,0,0,0,        0,0,0,              0,SEL_ALU,0,0,          0,0,1);
`else
        add_vec(0,0,0,0,        1,5,32'hDEADBEEF,   0,SEL_ALU,0,0,          0,0,1); // accept N
        add_vec(0,0,0,0,        0,0,0,              1,SEL_MD,5,32'hDEADBEEF,0,1,1); // write N+1
`endif
        add_vec(0,0,0,0,        1,0,32'h1234,       0,SEL_ALU,0,0,          0,0,1); // md rd=0
        add_vec(0,0,0,0,        0,0,0,              0,SEL_ALU,0,0,          0,0,1); // dropped
        add_vec(1,1,1,SEL_ALU,  1,7,32'h77,         1,SEL_ALU,1,0,          0,0,1); // starve setup
        for (int i = 0; i < STARVE_LIMIT; i++)
            add_vec(1,1,1,SEL_ALU, 0,0,0,           1,SEL_ALU,1,0,          0,1,1); // pipe wins
        add_vec(1,1,1,SEL_ALU,  0,0,0,              1,SEL_MD,7,32'h77,      1,1,1); // forced stall
        add_vec(1,1,1,SEL_ALU,  0,0,0,              1,SEL_ALU,1,0,          0,0,1); // pipe resumes
        add_vec(1,1,2,SEL_ALU,  1,9,32'h99,         1,SEL_ALU,2,0,          0,0,1); // pend rd=9
        add_vec(1,1,9,SEL_LINK, 0,0,0,              1,SEL_LINK,9,0,         0,1,1); // WAW squash
        add_vec(0,0,0,0,        0,0,0,              0,SEL_ALU,0,0,          0,1,1); // dead drain
        add_vec(0,0,0,0,        0,0,0,              0,SEL_ALU,0,0,          0,0,1);
        add_vec(1,1,12,SEL_ALU, 1,12,32'hC,         1,SEL_ALU,12,0,         0,0,1); // same-cycle squash
        add_vec(0,0,0,0,        0,0,0,              0,SEL_ALU,0,0,          0,1,1); // dead drain
        add_vec(0,0,0,0,        0,0,0,              0,SEL_ALU,0,0,          0,0,1);
        add_vec(1,1,1,SEL_ALU,  1,20,32'h20,        1,SEL_ALU,1,0,          0,0,1); // fill 1
        add_vec(1,1,1,SEL_ALU,  1,21,32'h21,        1,SEL_ALU,1,0,          0,1,1); // fill 2
        add_vec(1,1,1,SEL_ALU,  1,22,32'h22,        1,SEL_ALU,1,0,          0,2,0); // full
        add_vec(0,0,0,0,        1,22,32'h22,        1,SEL_MD,20,32'h20,     0,2,0); // first pop
        add_vec(0,0,0,0,        1,22,32'h22,        1,SEL_MD,21,32'h21,     0,1,1); // third accepted
        add_vec(0,0,0,0,        0,0,0,              1,SEL_MD,22,32'h22,     0,1,1);
        add_vec(0,0,0,0,        0,0,0,              0,SEL_ALU,0,0,          0,0,1);

        foreach (vecs[i]) begin
            @(posedge clk);
            #1 drive(vecs[i].pv, vecs[i].pw, vecs[i].prd, vecs[i].psel,
                     vecs[i].mv, vecs[i].mrd, vecs[i].mdat);
            @(negedge clk);
            check_outs($sformatf("vec%0d", i), vecs[i].we, vecs[i].sel, vecs[i].addr,
                       vecs[i].dat, vecs[i].stall, vecs[i].cnt, vecs[i].rdy);
        end

        // ------------------------------------- async reset mid-operation
        @(posedge clk); #1 drive(1, 1, 1, SEL_ALU, 1, 10, 32'h10);
        @(posedge clk); #1 drive(1, 1, 1, SEL_ALU, 1, 11, 32'h11);
        @(posedge clk); #1 drive(1, 1, 1, SEL_ALU, 0, 0, 0);
        #2 check_outs("pre_reset", 1, SEL_ALU, 1, 0, 0, 2, 0);
        #1 rst_n = 1'b0;
        #1 check_outs("reset_async", 0, SEL_ALU, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_outs($sformatf("post_reset%0d", i), 0, SEL_ALU, 0, 0, 0, 0, 1);
        end

        // ------------------------------------- scoreboarded result stream
        offering    = 1'b1;
        offers_left = 8;
        o_rd        = 5'(1 + $urandom_range(0, 29));
        o_dat       = $urandom;
        k           = 0;
        while ((offering || sb.size() != 0) && k < 60) begin
            pbusy = ((k % 3) == 2);
            @(posedge clk);
            #1 drive(pbusy, pbusy, 31, SEL_MEM, offering, o_rd, o_dat);
            @(negedge clk);
            if (offering && bus_if.md_ready_o) begin
                e.rd = o_rd; e.data = o_dat; e.cyc = k;
                sb.push_back(e);
                offers_left--;
                if (offers_left == 0) begin
                    offering = 1'b0;
                end else begin
                    o_rd  = 5'(1 + $urandom_range(0, 29));
                    o_dat = $urandom;
                end
            end
            if (bus_if.rf_we_o && bus_if.wb_sel_o == SEL_MD) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_unexpected: got write rd=%0d data=%h, want no md write",
                             bus_if.rf_addr_o, bus_if.md_data_o);
                end else begin
                    e = sb.pop_front();
                    if (bus_if.rf_addr_o !== e.rd || bus_if.md_data_o !== e.data ||
                        k < e.cyc + LAT_MIN) begin
                        n_err++;
                        $display("FAIL sb_write: got rd=%0d data=%h cyc=%0d, want rd=%0d data=%h cyc>=%0d",
                                 bus_if.rf_addr_o, bus_if.md_data_o, k, e.rd, e.data, e.cyc + LAT_MIN);
                    end else begin
                        $display("sb_write ok: rd=%0d data=%h accepted %0d written %0d",
                                 e.rd, e.data, e.cyc, k);
                    end
                end
            end
            k++;
        end
        n_vec++;
        if (offering || sb.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: got %0d pending, %0d unoffered after %0d cycles, want 0 and 0",
                     sb.size(), offers_left, k);
        end
        drive(0, 0, 0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
